// File: rtl/cycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cycle_sequencer_pkg
// Shared CPU definitions used by the cycle sequencer and by control:
//   seq_state_t      - sequencer state encoding (C0, C1, INT, ERR)
//   IRQ_VEC_DEFAULT  - default interrupt jump target
//   TIMER_W          - width of the memory wait counter
// -----------------------------------------------------------------------------
package cycle_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_C0  = 2'd0,  // first cycle of every instruction
    ST_C1  = 2'd1,  // memory second cycle, may stretch with wait states
    ST_INT = 2'd2,  // single interrupt-entry cycle
    ST_ERR = 2'd3   // halted after a memory timeout, left only by rst
  } seq_state_t;

  localparam logic [7:0] IRQ_VEC_DEFAULT = 8'h08;
  localparam int         TIMER_W         = 8;

endpackage

// File: rtl/cycle_sequencer_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Counts wait cycles spent in the memory second cycle and flags when the
// count has reached the configured timeout.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset, clears the count
//   i_clr   in   load-clear: force the count to zero
//   i_en    in   increment the count by one
//   o_count out  current count
//   o_term  out  count equals TIMEOUT
// -----------------------------------------------------------------------------
module wait_timer
  import cycle_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [TIMER_W-1:0] o_count,
  output logic               o_term
);

  localparam logic [TIMER_W-1:0] L_TERM = TIMER_W'(TIMEOUT);

  logic [TIMER_W-1:0] r_count;

  // The sequencer leaves C1 once the count hits TIMEOUT (at most 255), so a
  // plain increment can never wrap in normal use.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == L_TERM);

endmodule

// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
// Two-cycle instruction sequencer with memory wait states, bus timeout and a
// single-cycle interrupt entry.
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   inst[7:0]  in   current instruction byte; bit 7 selects a memory cycle
//   mem_ready  in   memory acknowledge for the current access
//   irq        in   level-sensitive interrupt request (sampled at boundaries)
//   nCLI       in   active-low clear-interrupt-enable strobe
//   ei         in   set-interrupt-enable pulse
//   cycle      out  1 in the memory second cycle
//   ncycle     out  complement of cycle
//   ir_load    out  latch next instruction byte
//   pc_inc     out  advance program counter
//   mem_req    out  memory access in progress
//   int_ack    out  interrupt-entry cycle
//   int_vec    out  IRQ_VEC during int_ack, else 0
//   ie         out  interrupt-enable flag
//   bus_err    out  sticky memory-timeout flag
// -----------------------------------------------------------------------------
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [7:0]  IRQ_VEC = IRQ_VEC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inst,
  input  logic       mem_ready,
  input  logic       irq,
  input  logic       nCLI,
  input  logic       ei,
  output logic       cycle,
  output logic       ncycle,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       mem_req,
  output logic       int_ack,
  output logic [7:0] int_vec,
  output logic       ie,
  output logic       bus_err
);

  seq_state_t r_state;
  seq_state_t w_next;

  logic r_ie;
  logic r_bus_err;

  logic w_cycle;
  logic w_ir_load;
  logic w_pc_inc;
  logic w_mem_req;
  logic w_int_ack;
  logic w_boundary;
  logic w_take_int;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_tmr_term;

  logic [TIMER_W-1:0] w_tmr_count;
  logic               w_unused_sig;

  // Only the opcode class bit matters here; the count is exported for debug
  // visibility by the timer but not needed by the FSM.
  assign w_unused_sig = ^{inst[6:0], w_tmr_count};

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_count (w_tmr_count),
    .o_term  (w_tmr_term)
  );

  // The counter is held at zero whenever we are not in C1, so every entry to
  // C1 starts counting from 0.
  assign w_tmr_clr = (r_state != ST_C1);

  // An instruction boundary with a pending, enabled interrupt diverts to INT
  // instead of fetching; irq itself is never remembered.
  assign w_take_int = w_boundary && irq && r_ie;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_C0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cycle    = 1'b0;
    w_ir_load  = 1'b0;
    w_pc_inc   = 1'b0;
    w_mem_req  = 1'b0;
    w_int_ack  = 1'b0;
    w_boundary = 1'b0;
    w_tmr_en   = 1'b0;

    case (r_state)
      ST_C0: begin
        if (inst[7]) begin
          w_next = ST_C1;
        end else begin
          w_boundary = 1'b1;
        end
      end

      ST_C1: begin
        w_cycle   = 1'b1;
        w_mem_req = 1'b1;
        // A ready on the terminal count still completes normally.
        if (mem_ready) begin
          w_boundary = 1'b1;
        end else if (w_tmr_term) begin
          w_next = ST_ERR;
        end else begin
          w_tmr_en = 1'b1;
        end
      end

      ST_INT: begin
        w_int_ack = 1'b1;
        w_next    = ST_C0;
      end

      ST_ERR: begin
        w_next = ST_ERR;
      end

      default: begin
        w_next = ST_C0;
      end
    endcase

    if (w_boundary) begin
      if (w_take_int) begin
        w_next = ST_INT;
      end else begin
        w_ir_load = 1'b1;
        w_pc_inc  = 1'b1;
        w_next    = ST_C0;
      end
    end
  end

  // Interrupt enable, highest priority first: reset, INT entry, nCLI, ei.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie <= 1'b0;
    end else if (w_next == ST_INT) begin
      r_ie <= 1'b0;
    end else if (!nCLI) begin
      r_ie <= 1'b0;
    end else if (ei) begin
      r_ie <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_err <= 1'b0;
    end else if (w_next == ST_ERR) begin
      r_bus_err <= 1'b1;
    end
  end

  // Strobes are masked while rst is high so an operation interrupted by reset
  // never advances the PC or loads the IR.
  assign cycle   = w_cycle   && !rst;
  assign ncycle  = ~cycle;
  assign ir_load = w_ir_load && !rst;
  assign pc_inc  = w_pc_inc  && !rst;
  assign mem_req = w_mem_req && !rst;
  assign int_ack = w_int_ack && !rst;
  assign int_vec = int_ack ? IRQ_VEC : 8'h00;
  assign ie      = r_ie;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_cycle_sequencer.sv
module tb_cycle_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] inst;
  logic       mem_ready;
  logic       irq;
  logic       nCLI;
  logic       ei;
  logic       cycle;
  logic       ncycle;
  logic       ir_load;
  logic       pc_inc;
  logic       mem_req;
  logic       int_ack;
  logic [7:0] int_vec;
  logic       ie;
  logic       bus_err;

  int n_checks;
  int n_errors;

  cycle_sequencer #(
    .TIMEOUT (4),
    .IRQ_VEC (8'h08)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .mem_ready (mem_ready),
    .irq       (irq),
    .nCLI      (nCLI),
    .ei        (ei),
    .cycle     (cycle),
    .ncycle    (ncycle),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .mem_req   (mem_req),
    .int_ack   (int_ack),
    .int_vec   (int_vec),
    .ie        (ie),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well away from the rising edge.
  task automatic drive(input logic r, input logic [7:0] in, input logic mr,
                       input logic q, input logic ncli, input logic e);
    @(negedge clk);
    rst = r; inst = in; mem_ready = mr; irq = q; nCLI = ncli; ei = e;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, ncycle, ir_load, pc_inc, mem_req, int_ack} !== 6'b010000) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b required 010000",
               {cycle, ncycle, ir_load, pc_inc, mem_req, int_ack});
    end
    n_checks++;
    if ({ie, bus_err, int_vec} !== 10'h000) begin
      n_errors++;
      $display("FAIL reset_flags: got ie=%b bus_err=%b int_vec=%h required 0 0 00",
               ie, bus_err, int_vec);
    end
  endtask

  task automatic test_nonmem();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({cycle, ncycle, ir_load, pc_inc, mem_req} !== 5'b01110) begin
        n_errors++;
        $display("FAIL nonmem_cyc%0d: got %b required 01110", i,
                 {cycle, ncycle, ir_load, pc_inc, mem_req});
      end
    end
  endtask

  task automatic test_mem();
    drive(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, ncycle, ir_load, pc_inc, mem_req} !== 5'b01000) begin
      n_errors++;
      $display("FAIL mem_c0: got %b required 01000",
               {cycle, ncycle, ir_load, pc_inc, mem_req});
    end
    drive(1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, ncycle, ir_load, pc_inc, mem_req} !== 5'b10111) begin
      n_errors++;
      $display("FAIL mem_c1: got %b required 10111",
               {cycle, ncycle, ir_load, pc_inc, mem_req});
    end
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, pc_inc} !== 2'b01) begin
      n_errors++;
      $display("FAIL mem_back_c0: got cycle,pc_inc=%b required 01", {cycle, pc_inc});
    end
  endtask

  task automatic test_wait_states();
    int incs;
    incs = 0;
    drive(1'b0, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'hA0, (i == 3), 1'b0, 1'b1, 1'b0);
      if (pc_inc) incs++;
      n_checks++;
      if ({cycle, mem_req} !== 2'b11) begin
        n_errors++;
        $display("FAIL wait_c1_%0d: got cycle,mem_req=%b required 11", i, {cycle, mem_req});
      end
    end
    n_checks++;
    if (incs !== 1) begin
      n_errors++;
      $display("FAIL wait_pc_inc_count: got %0d required 1", incs);
    end
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, bus_err, pc_inc} !== 3'b001) begin
      n_errors++;
      $display("FAIL wait_after: got cycle,bus_err,pc_inc=%b required 001",
               {cycle, bus_err, pc_inc});
    end
  endtask

  // Ready arrives exactly when the count equals TIMEOUT (5th C1 cycle).
  task automatic test_timeout_edge();
    drive(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, pc_inc, ir_load} !== 3'b111) begin
      n_errors++;
      $display("FAIL edge_ready: got cycle,pc_inc,ir_load=%b required 111",
               {cycle, pc_inc, ir_load});
    end
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, bus_err, pc_inc} !== 3'b001) begin
      n_errors++;
      $display("FAIL edge_no_err: got cycle,bus_err,pc_inc=%b required 001",
               {cycle, bus_err, pc_inc});
    end
  endtask

  task automatic test_timeout();
    drive(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({cycle, bus_err} !== 2'b10) begin
        n_errors++;
        $display("FAIL tmo_c1_%0d: got cycle,bus_err=%b required 10", i, {cycle, bus_err});
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h45, 1'b1, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({bus_err, cycle, ncycle, ir_load, pc_inc, mem_req, int_ack} !== 7'b1010000) begin
        n_errors++;
        $display("FAIL tmo_err_%0d: got %b required 1010000", i,
                 {bus_err, cycle, ncycle, ir_load, pc_inc, mem_req, int_ack});
      end
    end
    drive(1'b1, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({bus_err, cycle, pc_inc} !== 3'b001) begin
      n_errors++;
      $display("FAIL tmo_recover: got bus_err,cycle,pc_inc=%b required 001",
               {bus_err, cycle, pc_inc});
    end
  endtask

  task automatic test_interrupt();
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'h45, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ie !== 1'b1) begin
      n_errors++;
      $display("FAIL int_ie_set: got %b required 1", ie);
    end
    drive(1'b0, 8'h45, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({int_ack, int_vec, cycle, ie, pc_inc} !== {1'b1, 8'h08, 3'b000}) begin
      n_errors++;
      $display("FAIL int_entry: got ack=%b vec=%h cycle=%b ie=%b pc_inc=%b required 1 08 0 0 0",
               int_ack, int_vec, cycle, ie, pc_inc);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h45, 1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({int_ack, int_vec, ie, pc_inc} !== {1'b0, 8'h00, 2'b01}) begin
        n_errors++;
        $display("FAIL int_no_repeat_%0d: got ack=%b vec=%h ie=%b pc_inc=%b required 0 00 0 1",
                 i, int_ack, int_vec, ie, pc_inc);
      end
    end
  endtask

  // irq during a non-boundary cycle must not cause entry.
  task automatic test_irq_nonboundary();
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, int_ack} !== 2'b10) begin
      n_errors++;
      $display("FAIL nb_c1: got cycle,int_ack=%b required 10", {cycle, int_ack});
    end
    drive(1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({int_ack, cycle, ie, pc_inc} !== 4'b0011) begin
      n_errors++;
      $display("FAIL nb_after: got int_ack,cycle,ie,pc_inc=%b required 0011",
               {int_ack, cycle, ie, pc_inc});
    end
  endtask

  task automatic test_enable_conflict();
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h45, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ie !== 1'b0) begin
      n_errors++;
      $display("FAIL conflict_ie: got %b required 0", ie);
    end
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({int_ack, pc_inc} !== 2'b01) begin
      n_errors++;
      $display("FAIL conflict_irq_ignored: got int_ack,pc_inc=%b required 01", {int_ack, pc_inc});
    end
  endtask

  task automatic test_reset_mid_c1();
    drive(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, ir_load, pc_inc, mem_req} !== 4'b0000) begin
      n_errors++;
      $display("FAIL rst_mid_c1: got %b required 0000", {cycle, ir_load, pc_inc, mem_req});
    end
    drive(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({cycle, pc_inc} !== 2'b01) begin
      n_errors++;
      $display("FAIL rst_mid_c1_after: got cycle,pc_inc=%b required 01", {cycle, pc_inc});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; inst = 8'h00; mem_ready = 1'b0; irq = 1'b0; nCLI = 1'b1; ei = 1'b0;
    test_reset();
    test_nonmem();
    test_mem();
    test_wait_states();
    test_timeout_edge();
    test_timeout();
    test_interrupt();
    test_irq_nonboundary();
    test_enable_conflict();
    test_reset_mid_c1();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
